exec_cdb_stage: RTL and testbench

// - Execute stage directly downstream of the reservation stations: takes one ready op per cycle
//   (operands already read from regbank), computes it, broadcasts result on the common data bus (CDB).
// - Three functional units:
//   - single-cycle add/sub,
//   - 3-stage pipelined multiplier,
//   - iterative 16-step divider.
// - Single-port CDB output, fixed-priority arbitration, valid/ready backpressure.

---
 rtl/tomasulo_pkg.sv | 34 +++
 rtl/div_iter.sv | 90 +++++++++
 rtl/exec_cdb_stage.sv | 154 +++++++++++++++
 tb/tb_exec_cdb_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: function codes, default widths,
// the CDB packet layout and the divider FSM state type. Imported by the
// execute stage, reservation stations and ROB.
package tomasulo_pkg;

    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned ROBW_DEF    = 3;
    localparam int unsigned RDW_DEF     = 4;
    localparam int unsigned MUL_LAT_DEF = 3;

    typedef enum logic [3:0] {
        FUNC_ADD = 4'd0,
        FUNC_SUB = 4'd1,
        FUNC_MUL = 4'd2,
        FUNC_DIV = 4'd3,
        FUNC_LD  = 4'd4,
        FUNC_ST  = 4'd5,
        FUNC_BEQ = 4'd6,
        FUNC_BNE = 4'd7
    } func_e;

    typedef struct packed {
        logic [DW_DEF-1:0]   data;
        logic [ROBW_DEF-1:0] rob;
        logic [RDW_DEF-1:0]  rd;
    } cdb_pkt_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk1, rst_n      clock, asynchronous active-low reset
//   start            accept dividend/divisor (only honoured while idle)
//   dividend/divisor DW-bit unsigned operands
//   ack              result consumed; DONE returns to IDLE
//   idle             ready for a new start
//   done             quotient valid and held until ack
//   quotient         DW-bit result ('1 for divide by zero)
module div_iter
    import tomasulo_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          ack,
    output logic          idle,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int unsigned CW = $clog2(DW);

    div_state_e    state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rem, quo, dvsr;
    logic [DW:0]   shifted, diff;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= DIV_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (start) state_nx = (divisor == '0) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == '0) state_nx = DIV_DONE;
            DIV_DONE: if (ack) state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
    end

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while new quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem, quo[DW-1]};
        diff    = shifted - {1'b0, dvsr};
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        rem  <= '0;
                        dvsr <= divisor;
                        cnt  <= CW'(DW - 1);
                        quo  <= (divisor == '0) ? '1 : dividend;
                    end
                end
                DIV_RUN: begin
                    if (!diff[DW]) begin
                        rem <= diff[DW-1:0];
                        quo <= {quo[DW-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DW-1:0];
                        quo <= {quo[DW-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign idle     = (state == DIV_IDLE);
    assign done     = (state == DIV_DONE);
    assign quotient = quo;

endmodule

// File: rtl/exec_cdb_stage.sv
// Execute stage behind the reservation stations: add/sub, pipelined multiply
// and iterative divide, results broadcast on a single registered CDB port.
// Ports:
//   clk1, rst_n                 clock, asynchronous active-low reset
//   issue_*                     op from RS (valid, func, operands, ROB tag, rd)
//   add_free/mul_free/div_free  unit can accept an op this cycle
//   cdb_valid/cdb_ready         CDB handshake
//   cdb_data/cdb_rob/cdb_rd     broadcast result
module exec_cdb_stage
    import tomasulo_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned ROBW    = ROBW_DEF,
    parameter int unsigned RDW     = RDW_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [3:0]      issue_func,
    input  logic [DW-1:0]   issue_rs1,
    input  logic [DW-1:0]   issue_rs2,
    input  logic [ROBW-1:0] issue_rob,
    input  logic [RDW-1:0]  issue_rd,
    output logic            add_free,
    output logic            mul_free,
    output logic            div_free,
    output logic            cdb_valid,
    input  logic            cdb_ready,
    output logic [DW-1:0]   cdb_data,
    output logic [ROBW-1:0] cdb_rob,
    output logic [RDW-1:0]  cdb_rd
);

    // The mul hold register is the last of the MUL_LAT stages.
    localparam int unsigned NSTG = MUL_LAT - 1;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [ROBW-1:0] rob;
        logic [RDW-1:0]  rd;
    } pkt_t;

    logic            cdb_load, add_gnt, mul_gnt, div_gnt;
    logic            iss_add, iss_mul, iss_div;
    logic [DW-1:0]   add_res, mul_res;
    logic            add_v;
    pkt_t            add_pkt;
    logic            mul_v   [NSTG];
    pkt_t            mul_pkt [NSTG];
    logic            mul_hv;
    pkt_t            mul_hpkt;
    logic            div_idle, div_done;
    logic [DW-1:0]   div_q;
    logic [ROBW-1:0] div_rob;
    logic [RDW-1:0]  div_rd;

    // Fixed priority div > mul > add; the CDB register reloads whenever it is
    // empty or its current result is being taken.
    always_comb begin
        cdb_load = !cdb_valid || cdb_ready;
        div_gnt  = cdb_load && div_done;
        mul_gnt  = cdb_load && mul_hv && !div_done;
        add_gnt  = cdb_load && add_v && !div_done && !mul_hv;
        add_free = !add_v || add_gnt;
        mul_free = !mul_hv || mul_gnt;
        div_free = div_idle;
        iss_add  = issue_valid && (issue_func == FUNC_ADD || issue_func == FUNC_SUB) && add_free;
        iss_mul  = issue_valid && (issue_func == FUNC_MUL) && mul_free;
        iss_div  = issue_valid && (issue_func == FUNC_DIV) && div_free;
        add_res  = (issue_func == FUNC_SUB) ? issue_rs1 - issue_rs2 : issue_rs1 + issue_rs2;
        mul_res  = issue_rs1 * issue_rs2;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            add_v   <= 1'b0;
            add_pkt <= '0;
        end else if (iss_add) begin
            add_v   <= 1'b1;
            add_pkt <= '{data: add_res, rob: issue_rob, rd: issue_rd};
        end else if (add_gnt) begin
            add_v   <= 1'b0;
        end
    end

    // Whole multiplier pipe advances only when the hold register can move.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSTG; i++) begin
                mul_v[i]   <= 1'b0;
                mul_pkt[i] <= '0;
            end
            mul_hv   <= 1'b0;
            mul_hpkt <= '0;
        end else if (mul_free) begin
            mul_hv   <= mul_v[NSTG-1];
            mul_hpkt <= mul_pkt[NSTG-1];
            for (int unsigned i = NSTG - 1; i > 0; i--) begin
                mul_v[i]   <= mul_v[i-1];
                mul_pkt[i] <= mul_pkt[i-1];
            end
            mul_v[0]   <= iss_mul;
            mul_pkt[0] <= '{data: mul_res, rob: issue_rob, rd: issue_rd};
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            div_rob <= '0;
            div_rd  <= '0;
        end else if (iss_div) begin
            div_rob <= issue_rob;
            div_rd  <= issue_rd;
        end
    end

    div_iter #(.DW(DW)) u_div (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .start    (iss_div),
        .dividend (issue_rs1),
        .divisor  (issue_rs2),
        .ack      (div_gnt),
        .idle     (div_idle),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_rob   <= '0;
            cdb_rd    <= '0;
        end else if (cdb_load) begin
            cdb_valid <= div_gnt || mul_gnt || add_gnt;
            if (div_gnt) begin
                cdb_data <= div_q;
                cdb_rob  <= div_rob;
                cdb_rd   <= div_rd;
            end else if (mul_gnt) begin
                cdb_data <= mul_hpkt.data;
                cdb_rob  <= mul_hpkt.rob;
                cdb_rd   <= mul_hpkt.rd;
            end else if (add_gnt) begin
                cdb_data <= add_pkt.data;
                cdb_rob  <= add_pkt.rob;
                cdb_rd   <= add_pkt.rd;
            end
        end
    end

endmodule

// File: tb/tb_exec_cdb_stage.sv
module tb_exec_cdb_stage;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_func = '0;
    logic [15:0] issue_rs1 = '0, issue_rs2 = '0;
    logic [2:0]  issue_rob = '0;
    logic [3:0]  issue_rd = '0;
    logic        add_free, mul_free, div_free;
    logic        cdb_valid;
    logic        cdb_ready = 1'b1;
    logic [15:0] cdb_data;
    logic [2:0]  cdb_rob;
    logic [3:0]  cdb_rd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  rob;
        logic [3:0]  rd;
    } pkt_t;

    typedef struct {
        pkt_t pkt;
        int   cyc;
    } log_t;

    pkt_t q_add[$], q_mul[$], q_div[$];
    log_t log_q[$];

    exec_cdb_stage #(.DW(16), .ROBW(3), .RDW(4), .MUL_LAT(3)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_func  (issue_func),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rob   (issue_rob),
        .issue_rd    (issue_rd),
        .add_free    (add_free),
        .mul_free    (mul_free),
        .div_free    (div_free),
        .cdb_valid   (cdb_valid),
        .cdb_ready   (cdb_ready),
        .cdb_data    (cdb_data),
        .cdb_rob     (cdb_rob),
        .cdb_rd      (cdb_rd)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: arithmetic rules only, no notion of pipeline or FSM.
    function automatic logic [15:0] ref_res(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: begin p = 32'(a) * 32'(b); return p[15:0]; end
            4'd3: return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return 16'd0;
        endcase
    endfunction

    // Drives one op (caller is at a negedge), decides acceptance from the
    // free flag like the RS would, and returns just after the accepting edge.
    task automatic issue_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] rob, input logic [3:0] rd);
        bit   acc;
        pkt_t e;
        issue_valid = 1'b1;
        issue_func  = f;
        issue_rs1   = a;
        issue_rs2   = b;
        issue_rob   = rob;
        issue_rd    = rd;
        #1;
        e = '{data: ref_res(f, a, b), rob: rob, rd: rd};
        case (f)
            4'd0, 4'd1: acc = add_free;
            4'd2:       acc = mul_free;
            4'd3:       acc = div_free;
            default:    acc = 1'b0;
        endcase
        if (acc) begin
            case (f)
                4'd0, 4'd1: q_add.push_back(e);
                4'd2:       q_mul.push_back(e);
                default:    q_div.push_back(e);
            endcase
        end
        @(posedge clk1);
        #1;
        acc_cyc     = cyc;
        issue_valid = 1'b0;
    endtask

    task automatic wait_log(input string nm, input int n, input int maxc);
        int c = 0;
        while (log_q.size() < n && c < maxc) begin
            @(negedge clk1);
            #3;
            c++;
        end
        chk(nm, 64'(log_q.size() >= n), 64'd1);
    endtask

    // Monitor: compares every accepted CDB result against the head of the
    // per-unit expectation queues and checks hold-stability under backpressure.
    initial begin : monitor
        pkt_t got;
        pkt_t prev;
        bit   stall;
        bit   hit;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk1);
            #2;
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                got = '{data: cdb_data, rob: cdb_rob, rd: cdb_rd};
                if (stall) chk("cdb_stable", 64'({cdb_valid, got}), 64'({1'b1, prev}));
                if (cdb_valid && cdb_ready) begin
                    log_q.push_back('{pkt: got, cyc: cyc});
                    total++;
                    hit = 1'b1;
                    if (q_div.size() > 0 && q_div[0] == got)      void'(q_div.pop_front());
                    else if (q_mul.size() > 0 && q_mul[0] == got) void'(q_mul.pop_front());
                    else if (q_add.size() > 0 && q_add[0] == got) void'(q_add.pop_front());
                    else hit = 1'b0;
                    if (!hit) begin
                        bad++;
                        $display("FAIL cdb_match: got %h/%0d/%0d want a pending head (div=%0d mul=%0d add=%0d pending)",
                                 got.data, got.rob, got.rd, q_div.size(), q_mul.size(), q_add.size());
                    end
                end
                stall = cdb_valid && !cdb_ready;
                prev  = got;
            end
        end
    end

    initial begin : main
        int a0;
        int c;
        bit flag;
        logic [3:0]  f;
        logic [15:0] a, b;

        // Reset state
        repeat (3) @(negedge clk1);
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_pkt", 64'({cdb_data, cdb_rob, cdb_rd}), 64'd0);
        chk("rst_free", 64'({add_free, mul_free, div_free}), 64'b111);
        @(negedge clk1);
        rst_n = 1'b1;

        // 1: single add
        log_q.delete();
        @(negedge clk1); issue_op(4'd0, 16'd5, 16'd7, 3'd2, 4'd3);
        a0 = acc_cyc;
        wait_log("wait_add", 1, 10);
        chk("add_pkt", 64'(log_q[0].pkt), 64'({16'd12, 3'd2, 4'd3}));
        chk("add_lat", 64'(log_q[0].cyc - a0), 64'd1);

        // 2: sub wraps, then back-to-back adds
        log_q.delete();
        @(negedge clk1); issue_op(4'd1, 16'd3, 16'd5, 3'd1, 4'd1);
        wait_log("wait_sub", 1, 10);
        chk("sub_data", 64'(log_q[0].pkt.data), 64'hFFFE);
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1); issue_op(4'd0, 16'(i), 16'd100, 3'(i), 4'(i + 8));
            if (i == 0) a0 = acc_cyc;
        end
        wait_log("wait_b2b", 4, 12);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_data", 64'(log_q[i].pkt.data), 64'(i + 100));
            chk("b2b_cyc", 64'(log_q[i].cyc - a0), 64'(i + 1));
        end

        // 3: multiply latency
        log_q.delete();
        @(negedge clk1); issue_op(4'd2, 16'd300, 16'd300, 3'd1, 4'd5);
        a0 = acc_cyc;
        wait_log("wait_mul", 1, 10);
        chk("mul_data", 64'(log_q[0].pkt.data), 64'h5F90);
        chk("mul_lat", 64'(log_q[0].cyc - a0), 64'd3);

        // 4: divide latency, busy flag, divide by zero
        log_q.delete();
        @(negedge clk1); issue_op(4'd3, 16'd100, 16'd7, 3'd4, 4'd2);
        a0 = acc_cyc;
        flag = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (div_free !== 1'b0) flag = 1'b1;
            @(posedge clk1);
            #1;
        end
        chk("div_busy", 64'(flag), 64'd0);
        wait_log("wait_div", 1, 10);
        chk("div_data", 64'(log_q[0].pkt.data), 64'd14);
        chk("div_lat", 64'(log_q[0].cyc - a0), 64'd17);
        log_q.delete();
        @(negedge clk1); issue_op(4'd3, 16'd9, 16'd0, 3'd6, 4'd7);
        a0 = acc_cyc;
        wait_log("wait_div0", 1, 10);
        chk("div0_data", 64'(log_q[0].pkt.data), 64'hFFFF);
        chk("div0_lat", 64'(log_q[0].cyc - a0), 64'd1);

        // 3b: mul reaches its hold on the same edge the divider finishes
        log_q.delete();
        @(negedge clk1); issue_op(4'd3, 16'd100, 16'd7, 3'd5, 4'd6);
        a0 = acc_cyc;
        repeat (13) @(negedge clk1);
        @(negedge clk1); issue_op(4'd2, 16'd300, 16'd300, 3'd1, 4'd2);
        wait_log("wait_coll", 2, 30);
        chk("coll_first", 64'(log_q[0].pkt.data), 64'd14);
        chk("coll_first_cyc", 64'(log_q[0].cyc - a0), 64'd17);
        chk("coll_second", 64'(log_q[1].pkt.data), 64'h5F90);
        chk("coll_second_cyc", 64'(log_q[1].cyc - a0), 64'd18);

        // 5: backpressure with all three units pending
        log_q.delete();
        @(negedge clk1); cdb_ready = 1'b0;
        issue_op(4'd3, 16'd9, 16'd0, 3'd0, 4'd0);
        @(negedge clk1); issue_op(4'd2, 16'd300, 16'd300, 3'd1, 4'd1);
        @(negedge clk1); issue_op(4'd0, 16'd5, 16'd7, 3'd2, 4'd2);
        @(negedge clk1); issue_op(4'd0, 16'd1, 16'd1, 3'd3, 4'd3);
        repeat (5) @(negedge clk1);
        #3;
        chk("bp_valid", 64'(cdb_valid), 64'd1);
        chk("bp_data", 64'(cdb_data), 64'hFFFF);
        chk("bp_add_free", 64'(add_free), 64'd0);
        chk("bp_mul_free", 64'(mul_free), 64'd0);
        @(negedge clk1); cdb_ready = 1'b1;
        wait_log("wait_bp", 3, 15);
        chk("bp_order0", 64'(log_q[0].pkt.data), 64'hFFFF);
        chk("bp_order1", 64'(log_q[1].pkt.data), 64'h5F90);
        chk("bp_order2", 64'(log_q[2].pkt.data), 64'h000C);
        repeat (3) @(negedge clk1);
        chk("bp_no_extra", 64'(log_q.size()), 64'd3);

        // 6: reset mid-divide / mid-multiply with a result stalled on the CDB
        @(negedge clk1); cdb_ready = 1'b0;
        issue_op(4'd0, 16'd1, 16'd1, 3'd7, 4'd1);
        @(negedge clk1); issue_op(4'd3, 16'd100, 16'd7, 3'd4, 4'd2);
        @(negedge clk1); issue_op(4'd2, 16'd3, 16'd3, 3'd5, 4'd3);
        @(negedge clk1);
        #3;
        chk("prerst_valid", 64'({cdb_valid, cdb_data}), 64'({1'b1, 16'd2}));
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(cdb_valid), 64'd0);
        chk("arst_pkt", 64'({cdb_data, cdb_rob, cdb_rd}), 64'd0);
        chk("arst_free", 64'({add_free, mul_free, div_free}), 64'b111);
        q_add.delete(); q_mul.delete(); q_div.delete(); log_q.delete();
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        cdb_ready = 1'b1;
        repeat (25) @(negedge clk1);
        #3;
        chk("no_stale", 64'(log_q.size()), 64'd0);
        @(negedge clk1); issue_op(4'd0, 16'd20, 16'd22, 3'd3, 4'd9);
        a0 = acc_cyc;
        wait_log("wait_post", 1, 10);
        chk("post_data", 64'(log_q[0].pkt.data), 64'd42);
        chk("post_lat", 64'(log_q[0].cyc - a0), 64'd1);

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            @(negedge clk1);
            cdb_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) begin
                f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                a = 16'($urandom_range(0, 65535));
                b = 16'($urandom_range(0, 65535));
                case ($urandom_range(0, 7))
                    0: b = 16'd0;
                    1: a = 16'hFFFF;
                    2: b = 16'($urandom_range(1, 15));
                    default: ;
                endcase
                issue_op(f, a, b, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            end
        end

        // Drain
        @(negedge clk1); cdb_ready = 1'b1;
        c = 0;
        while ((q_add.size() + q_mul.size() + q_div.size()) > 0 && c < 200) begin
            @(negedge clk1);
            c++;
        end
        repeat (5) @(negedge clk1);
        chk("drain_empty", 64'(q_add.size() + q_mul.size() + q_div.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
